// File: rtl/c_mem_seq_ctrl.sv
// C-matrix SRAM sequencer: zero-fills the array (CLEAR) or streams it out in
// row-major order through a 2-entry registered buffer (DRAIN).
//
// state    | meaning
// ---------+--------------------------------------------------
// ST_IDLE  | waiting for a command, cmd_ready high
// ST_CLEAR | one zero write per cycle until (M-1,N-1)
// ST_DRAIN | credit-gated reads, buffered output until last pop
module c_mem_seq_ctrl #(
  parameter int M      = 8,
  parameter int N      = 8,
  parameter int DATA_W = 32,
  parameter int BYTE_W = DATA_W / 8,
  parameter int ROW_W  = (M <= 1) ? 1 : $clog2(M),
  parameter int COL_W  = (N <= 1) ? 1 : $clog2(N),
  parameter int FIFO_D = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  input  logic              cmd_op,
  output logic              cmd_ready,
  output logic              busy,
  output logic              done,
  output logic              c_en,
  output logic              c_re,
  output logic [ROW_W-1:0]  c_row,
  output logic [COL_W-1:0]  c_col,
  input  logic [DATA_W-1:0] c_rdata,
  input  logic              c_rvalid,
  output logic              c_we_en,
  output logic              c_we,
  output logic [ROW_W-1:0]  c_wrow,
  output logic [COL_W-1:0]  c_wcol,
  output logic [DATA_W-1:0] c_wdata,
  output logic [BYTE_W-1:0] c_wmask,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ROW_W-1:0]  out_row,
  output logic [COL_W-1:0]  out_col,
  output logic              out_last
);

  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(M - 1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(N - 1);
  localparam int               CNT_W    = $clog2(FIFO_D + 1);
  localparam int               OCC_W    = CNT_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [ROW_W-1:0]  row;
    logic [COL_W-1:0]  col;
    logic              last;
  } entry_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_done;
  logic             w_done_nxt;

  logic [ROW_W-1:0] r_row;
  logic [COL_W-1:0] r_col;
  logic [ROW_W-1:0] w_row_nxt;
  logic [COL_W-1:0] w_col_nxt;
  logic             w_adv;
  logic             w_at_last;
  logic             w_accept;

  logic             r_rd_rem;
  logic             r_inflight;
  logic [ROW_W-1:0] r_tag_row;
  logic [COL_W-1:0] r_tag_col;
  logic             r_tag_last;

  entry_t           r_head;
  entry_t           r_tail;
  logic [CNT_W-1:0] r_cnt;
  entry_t           w_new;
  logic             w_push;
  logic             w_pop;
  logic [OCC_W-1:0] w_occ;
  logic             w_issue;

  assign w_accept  = cmd_valid && (r_state == ST_IDLE);
  assign w_at_last = (r_row == ROW_LAST) && (r_col == COL_LAST);
  assign w_pop     = (r_cnt != '0) && out_ready;
  // Returning data is only meaningful while draining; a read launched just
  // before a reset lands in IDLE and must be dropped.
  assign w_push    = c_rvalid && (r_state == ST_DRAIN);
  assign w_new     = {c_rdata, r_tag_row, r_tag_col, r_tag_last};

  // Occupancy after this cycle's pop, counting the read still in flight.
  assign w_occ   = OCC_W'(r_cnt) - OCC_W'(w_pop) + OCC_W'(r_inflight);
  assign w_issue = (r_state == ST_DRAIN) && r_rd_rem && (w_occ < OCC_W'(FIFO_D));

  assign out_valid = (r_cnt != '0);
  assign out_data  = r_head.data;
  assign out_row   = r_head.row;
  assign out_col   = r_head.col;
  assign out_last  = r_head.last;
  assign done      = r_done;
  assign c_wdata   = '0;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_done_nxt  = 1'b0;
    w_adv       = 1'b0;
    cmd_ready   = 1'b0;
    busy        = 1'b0;
    c_en        = 1'b0;
    c_re        = 1'b0;
    c_row       = '0;
    c_col       = '0;
    c_we_en     = 1'b0;
    c_we        = 1'b0;
    c_wrow      = '0;
    c_wcol      = '0;
    c_wmask     = '0;
    case (r_state)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          w_state_nxt = cmd_op ? ST_DRAIN : ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        busy    = 1'b1;
        c_we_en = 1'b1;
        c_we    = 1'b1;
        c_wrow  = r_row;
        c_wcol  = r_col;
        c_wmask = '1;
        w_adv   = 1'b1;
        if (w_at_last) begin
          w_state_nxt = ST_IDLE;
          w_done_nxt  = 1'b1;
        end
      end
      ST_DRAIN: begin
        busy = 1'b1;
        if (w_issue) begin
          c_en  = 1'b1;
          c_re  = 1'b1;
          c_row = r_row;
          c_col = r_col;
          w_adv = 1'b1;
        end
        if (w_pop && r_head.last) begin
          w_state_nxt = ST_IDLE;
          w_done_nxt  = 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Column-first walk; wrap is by compare so non-power-of-two sizes work.
  always_comb begin
    w_row_nxt = r_row;
    w_col_nxt = r_col;
    if (w_accept) begin
      w_row_nxt = '0;
      w_col_nxt = '0;
    end else if (w_adv) begin
      if (r_col == COL_LAST) begin
        w_col_nxt = '0;
        w_row_nxt = (r_row == ROW_LAST) ? '0 : r_row + ROW_W'(1);
      end else begin
        w_col_nxt = r_col + COL_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_row      <= '0;
      r_col      <= '0;
      r_rd_rem   <= 1'b0;
      r_inflight <= 1'b0;
      r_tag_row  <= '0;
      r_tag_col  <= '0;
      r_tag_last <= 1'b0;
      r_head     <= '0;
      r_tail     <= '0;
      r_cnt      <= '0;
    end else begin
      r_row      <= w_row_nxt;
      r_col      <= w_col_nxt;
      r_inflight <= w_issue;
      if (w_accept) begin
        r_rd_rem <= cmd_op;
      end else if (w_issue && w_at_last) begin
        r_rd_rem <= 1'b0;
      end
      if (w_issue) begin
        r_tag_row  <= r_row;
        r_tag_col  <= r_col;
        r_tag_last <= w_at_last;
      end
      case ({w_push, w_pop})
        2'b10: begin
          if (r_cnt == '0) begin
            r_head <= w_new;
          end else begin
            r_tail <= w_new;
          end
          r_cnt <= r_cnt + CNT_W'(1);
        end
        2'b01: begin
          r_head <= r_tail;
          r_cnt  <= r_cnt - CNT_W'(1);
        end
        2'b11: begin
          if (r_cnt == CNT_W'(1)) begin
            r_head <= w_new;
          end else begin
            r_head <= r_tail;
            r_tail <= w_new;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_c_mem_seq_ctrl.sv
// Scoreboard bench for c_mem_seq_ctrl at M=N=4 with a behavioural C-SRAM model.
module tb_c_mem_seq_ctrl;
  localparam int M      = 4;
  localparam int N      = 4;
  localparam int DATA_W = 32;
  localparam int BYTE_W = 4;
  localparam int ROW_W  = 2;
  localparam int COL_W  = 2;
  localparam int EW     = DATA_W + ROW_W + COL_W + 1;
  localparam int AW     = ROW_W + COL_W;

  logic              clk;
  logic              rst;
  logic              cmd_valid;
  logic              cmd_op;
  logic              cmd_ready;
  logic              busy;
  logic              done;
  logic              c_en;
  logic              c_re;
  logic [ROW_W-1:0]  c_row;
  logic [COL_W-1:0]  c_col;
  logic [DATA_W-1:0] c_rdata;
  logic              c_rvalid;
  logic              c_we_en;
  logic              c_we;
  logic [ROW_W-1:0]  c_wrow;
  logic [COL_W-1:0]  c_wcol;
  logic [DATA_W-1:0] c_wdata;
  logic [BYTE_W-1:0] c_wmask;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [ROW_W-1:0]  out_row;
  logic [COL_W-1:0]  out_col;
  logic              out_last;

  logic              tb_preload;
  logic              rdy_mode;
  int                cyc = 0;
  int                n_chk = 0;
  int                n_pass = 0;
  logic [DATA_W-1:0] mem [M][N];
  logic [EW-1:0]     exp_q[$];
  logic [AW-1:0]     exp_w[$];

  c_mem_seq_ctrl #(
    .M(M), .N(N), .DATA_W(DATA_W), .BYTE_W(BYTE_W),
    .ROW_W(ROW_W), .COL_W(COL_W), .FIFO_D(2)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_ready(cmd_ready),
    .busy(busy), .done(done),
    .c_en(c_en), .c_re(c_re), .c_row(c_row), .c_col(c_col),
    .c_rdata(c_rdata), .c_rvalid(c_rvalid),
    .c_we_en(c_we_en), .c_we(c_we), .c_wrow(c_wrow), .c_wcol(c_wcol),
    .c_wdata(c_wdata), .c_wmask(c_wmask),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_row(out_row), .out_col(out_col), .out_last(out_last)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // C-SRAM: one-cycle read latency, preload fills C[r][c] = r*16+c.
  always @(posedge clk) begin
    if (tb_preload) begin
      for (int r = 0; r < M; r++)
        for (int c = 0; c < N; c++)
          mem[r][c] <= DATA_W'(r * 16 + c);
    end else if (c_we_en && c_we) begin
      mem[c_wrow][c_wcol] <= c_wdata;
    end
    c_rvalid <= c_en && c_re;
    c_rdata  <= mem[c_row][c_col];
  end

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, exp, cyc);
  endtask

  task automatic push_drain(input bit pat);
    for (int r = 0; r < M; r++)
      for (int c = 0; c < N; c++)
        exp_q.push_back({(pat ? DATA_W'(r * 16 + c) : DATA_W'(0)), ROW_W'(r), COL_W'(c),
                         (r == M - 1) && (c == N - 1)});
  endtask

  task automatic issue_cmd(input logic op, output int acc);
    @(posedge clk); #1;
    cmd_valid = 1'b1;
    cmd_op    = op;
    @(negedge clk);
    chk("cmd_accept", 64'(cmd_ready), 64'(1));
    acc = cyc;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int lim, output int dc);
    logic ok;
    ok = 1'b0;
    dc = -1;
    for (int i = 0; i < lim; i++) begin
      @(negedge clk);
      if (done) begin
        ok = 1'b1;
        dc = cyc;
        break;
      end
    end
    chk("done_reached", 64'(ok), 64'(1));
  endtask

  initial begin : ready_drv
    int ph;
    ph = 0;
    out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (rdy_mode) begin
        out_ready = (ph == 0) || (ph == 3);
        ph = (ph + 1) % 4;
      end else begin
        out_ready = 1'b1;
        ph = 0;
      end
    end
  end

  initial begin : monitor
    int            occ;
    int            acc_c;
    int            done_due;
    logic          first_pend;
    logic          stall_prev;
    logic          pop_now;
    logic [EW-1:0] e;
    logic [EW-1:0] snap;
    logic [AW-1:0] w;
    occ = 0; acc_c = 0; done_due = -1;
    first_pend = 1'b0; stall_prev = 1'b0; snap = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        exp_q.delete();
        occ = 0; done_due = -1; first_pend = 1'b0; stall_prev = 1'b0;
      end else begin
        pop_now = out_valid && out_ready;
        if (done_due >= 0 && cyc == done_due) begin
          chk("done_pulse", 64'({done, cmd_ready}), 64'(2'b11));
          done_due = -1;
        end else if (done) begin
          chk("done_unexpected", 64'(done), 64'(0));
        end
        if (c_we_en || c_we || c_en || c_re)
          chk("ports_exclusive", 64'((c_we_en | c_we) & (c_en | c_re)), 64'(0));
        if (c_we_en || c_we) begin
          if (exp_w.size() == 0) chk("write_unexpected", 64'(1), 64'(0));
          else begin
            w = exp_w.pop_front();
            chk("clear_write", 64'({c_we_en, c_we, c_wrow, c_wcol, c_wdata, c_wmask}),
                64'({2'b11, w, 32'h0, 4'hF}));
          end
        end
        if (c_en || c_re)
          chk("read_credit", 64'({c_en, c_re, (occ - int'(pop_now)) < 2}), 64'(3'b111));
        if (first_pend && out_valid) begin
          chk("first_valid_latency", 64'(cyc - acc_c), 64'(3));
          first_pend = 1'b0;
        end
        if (stall_prev)
          chk("stall_stable", 64'({out_valid, out_data, out_row, out_col, out_last}),
              64'({1'b1, snap}));
        if (pop_now) begin
          chk("occupancy_le2", 64'(occ <= 2), 64'(1));
          if (exp_q.size() == 0) chk("pop_unexpected", 64'(1), 64'(0));
          else begin
            e = exp_q.pop_front();
            chk("drain_elem", 64'({out_data, out_row, out_col, out_last}), 64'(e));
            if (e[0]) done_due = cyc + 1;
          end
        end
        stall_prev = out_valid && !out_ready;
        snap = {out_data, out_row, out_col, out_last};
        occ = occ + int'(c_en && c_re) - int'(pop_now);
        if (cmd_valid && cmd_ready) begin
          acc_c = cyc;
          occ = 0;
          if (cmd_op) first_pend = 1'b1;
          else done_due = cyc + M * N + 1;
        end
      end
    end
  end

  initial begin : stim
    int   t;
    int   dc;
    int   nb;
    int   k;
    logic ok;
    rst = 1'b0; cmd_valid = 1'b0; cmd_op = 1'b0; tb_preload = 1'b0; rdy_mode = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_cmd_ready", 64'(cmd_ready), 64'(1));
    chk("rst_quiet", 64'({busy, done, c_en, c_re, c_we_en, c_we, out_valid, c_wmask}), 64'(0));
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("rel_idle", 64'({cmd_ready, busy, c_re, c_we, out_valid}), 64'(5'b10000));

    // CLEAR with a DRAIN request parked on cmd_valid behind it
    for (int r = 0; r < M; r++)
      for (int c = 0; c < N; c++)
        exp_w.push_back({ROW_W'(r), COL_W'(c)});
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_op = 1'b0;
    @(negedge clk);
    chk("clear_accept", 64'(cmd_ready), 64'(1));
    t = cyc;
    @(posedge clk); #1;
    cmd_op = 1'b1;
    nb = 0; ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) begin
        ok = 1'b1;
        break;
      end
      if (busy && !cmd_ready) nb++;
    end
    chk("clear_done_seen", 64'(ok), 64'(1));
    chk("clear_done_cycle", 64'(cyc - t), 64'(17));
    chk("clear_busy_cycles", 64'(nb), 64'(16));
    chk("accept_on_done", 64'(cmd_ready), 64'(1));
    push_drain(1'b0);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("drain_after_done", 64'({busy, c_re, c_row, c_col}), 64'(6'b110000));
    wait_done(100, dc);

    // preloaded pattern, consumer always ready
    @(posedge clk); #1;
    tb_preload = 1'b1;
    @(posedge clk); #1;
    tb_preload = 1'b0;
    push_drain(1'b1);
    issue_cmd(1'b1, t);
    wait_done(100, dc);
    chk("drain_done_cycle", 64'(dc - t), 64'(19));

    // consumer ready pattern 1,0,0,1
    rdy_mode = 1'b1;
    push_drain(1'b1);
    issue_cmd(1'b1, t);
    wait_done(200, dc);
    rdy_mode = 1'b0;

    // reset after five elements, then a fresh drain
    push_drain(1'b1);
    issue_cmd(1'b1, t);
    k = 0;
    for (int i = 0; i < 100 && k < 5; i++) begin
      @(negedge clk);
      if (out_valid && out_ready) k++;
    end
    chk("five_popped", 64'(k), 64'(5));
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("abort_idle", 64'({cmd_ready, busy, out_valid, done, c_re, c_we}), 64'(6'b100000));
    @(negedge clk);
    chk("abort_fifo_empty", 64'({out_valid, busy}), 64'(0));
    push_drain(1'b1);
    issue_cmd(1'b1, t);
    wait_done(100, dc);
    chk("restart_done_cycle", 64'(dc - t), 64'(19));

    repeat (3) @(negedge clk);
    chk("sb_out_empty", 64'(exp_q.size()), 64'(0));
    chk("sb_wr_empty", 64'(exp_w.size()), 64'(0));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
